cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the 4-bit CLA add/sub unit.
- Operands are split into 4-bit CLA groups, with one register stage per group, so ripple between groups becomes a pipeline.
- Accepts one operation per cycle under a valid/ready handshake and supports back-pressure.
- Reports carry-out, signed overflow and zero alongside the result.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- NGRP, WIDTH/4 (derived localparam, not overridable), number of 4-bit CLA groups; equals pipeline latency.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A−B (B inverted, carry-in 1); 0 = A+B (carry-in 0).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- res  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; in subtract mode 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  res == 0.

Behaviour:
- Reset: synchronous; all stage valid bits, out_valid, res, cout, ovf and zero are cleared to 0 on the clock edge with rst=1. In-flight data is discarded. Ports in_ready = 1 in the first cycle after reset.
- Stage k (k = 0..NGRP−1) computes bits [4k+3:4k] using 4-bit group generate/propagate lookahead and carry-in from stage k−1. Stage 0 carry-in is `sub`.
- Each stage forwards unprocessed upper operand bits, already-computed lower result bits, and its carry-out.
- Latency: a beat accepted at edge t appears at the outputs after edge t+NGRP−1, i.e. out_valid is asserted NGRP−1 cycles after the accepting edge. For WIDTH=4, the result is registered one cycle after acceptance.
- Throughput: one beat per cycle when out_ready = 1.
- Advance = !out_valid | out_ready. All stages shift together when advance = 1 and hold otherwise (global stall).
- in_ready = advance. This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Bubbles (stage valid = 0) propagate; data in invalid stages is don't-care, but output data registers hold their value while out_valid = 0.
- Flags are computed in the final stage:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero is evaluated on the final res.
  - cout is the raw carry in both modes.
- Simultaneous events: a beat accepted in the same cycle a result is consumed is legal and lossless.
- rst asserted mid-stream: all beats are dropped and no partial result is emitted.
- Results remain stable while out_valid = 1 and out_ready = 0.

Optional Feature:
- Macro: CLA_ADDSUB_SAT_EN.
- Defined: signed saturation. When ovf = 1, res is clamped to 2^(WIDTH−1)−1 if the true result is positive (A sign bit = 0 on add, or A sign bit = 0 on subtract), and to −2^(WIDTH−1) otherwise. Flags ovf and cout are still reported unclamped, and zero reflects the clamped res.
- Clamping is added in the final stage with no extra latency.
- Undefined: wrap-around result only; no saturation logic is synthesised.

Test Plan (WIDTH=16, NGRP=4):
- Subtract 0x0008−0x0005 → after 3 cycles: res=0x0003, cout=1, ovf=0, zero=0.
- Subtract 0x0005−0x000B → res=0xFFFA, cout=0, ovf=0; and subtract 0xFFFF−0xFFFF → res=0x0000, cout=1, zero=1.
- Add 0x7FFF+0x0001 → res=0x8000, ovf=1, cout=0 (with CLA_ADDSUB_SAT_EN: res=0x7FFF, ovf=1); subtract 0x8000−0x0001 → res=0x7FFF, ovf=1 (SAT: 0x8000).
- Add 0xFFFF+0x0001 → res=0x0000, cout=1, zero=1, ovf=0.
- Stream 8 back-to-back beats, with out_ready held low for 3 cycles mid-stream → in_ready drops in the same cycles, all 8 results arrive in order with no loss or duplication, and res is stable during the stall.
- Accept 3 beats, assert rst for 1 cycle → out_valid=0 next cycle, no stale results emitted afterwards, in_ready=1.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor. The operands are split into
//   4-bit lookahead groups. Each group has its own register stage, so the
//   carry between groups travels down the pipeline instead of rippling
//   through logic. Latency is NGRP = WIDTH/4 cycles. The valid/ready
//   handshake uses a global stall.
//
//   Optional feature macro: CLA_ADDSUB_SAT_EN
//     defined   -> the final stage clamps res to the signed limits on overflow
//     undefined -> res wraps modulo 2^WIDTH
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGRP = WIDTH / 4;

    // Signed limits used when saturation is enabled.
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // 4-bit lookahead group.
    // Returns {carry into bit 3, group carry-out, 4-bit sum}.
    function automatic logic [5:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (&p & ci);
        return {c[3], c[4], p ^ c[3:0]};
    endfunction

    // Pipeline stage registers. Stage k holds operands, the partial result
    // with groups 0..k filled in, and the carry out of group k.
    logic [NGRP-1:0]  vld_q, vld_d;
    logic [WIDTH-1:0] opa_q [NGRP];
    logic [WIDTH-1:0] opa_d [NGRP];
    logic [WIDTH-1:0] opb_q [NGRP];
    logic [WIDTH-1:0] opb_d [NGRP];
    logic [WIDTH-1:0] sum_q [NGRP];
    logic [WIDTH-1:0] sum_d [NGRP];
    logic [NGRP-1:0]  cy_q, cy_d;

    // Output registers. They are written only when a valid beat retires.
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Stage inputs, the lookahead results and the final-stage values.
    logic             advance;
    logic [NGRP-1:0]  src_v;
    logic [WIDTH-1:0] src_a [NGRP];
    logic [WIDTH-1:0] src_b [NGRP];
    logic [WIDTH-1:0] src_s [NGRP];
    logic [NGRP-1:0]  src_c;
    logic [5:0]       grp   [NGRP];
    logic [WIDTH-1:0] fin_raw;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cout;
    logic             fin_ovf;
    logic             fin_zero;

    // Handshake. The whole pipe moves together unless a result is stuck at
    // the output.
    always_comb begin
        advance  = !vld_q[NGRP-1] || out_ready;
        in_ready = advance;
    end

    // Select the inputs of each stage and evaluate its lookahead group.
    // Subtraction is A + ~B + 1: B is inverted once at entry and the stage-0
    // carry-in is `sub`.
    always_comb begin
        for (int k = 0; k < NGRP; k++) begin
            if (k == 0) begin
                src_v[k] = in_valid;
                src_a[k] = a;
                src_b[k] = b ^ {WIDTH{sub}};
                src_s[k] = '0;
                src_c[k] = sub;
            end else begin
                src_v[k] = vld_q[k-1];
                src_a[k] = opa_q[k-1];
                src_b[k] = opb_q[k-1];
                src_s[k] = sum_q[k-1];
                src_c[k] = cy_q[k-1];
            end
            grp[k] = cla4(src_a[k][4*k +: 4], src_b[k][4*k +: 4], src_c[k]);
        end
    end

    // Final stage: assemble the result, derive the flags, optionally saturate.
    always_comb begin
        fin_raw              = src_s[NGRP-1];
        fin_raw[WIDTH-1 -: 4] = grp[NGRP-1][3:0];
        fin_cout             = grp[NGRP-1][4];
        // Overflow: carry into the MSB differs from carry out of the MSB.
        fin_ovf              = grp[NGRP-1][5] ^ grp[NGRP-1][4];
`ifdef CLA_ADDSUB_SAT_EN
        // On overflow the true result has the sign of A, both for add
        // (operand signs equal) and for subtract (operand signs differ).
        if (fin_ovf) begin
            fin_res = src_a[NGRP-1][WIDTH-1] ? SMIN : SMAX;
        end else begin
            fin_res = fin_raw;
        end
`else
        fin_res              = fin_raw;
`endif
        fin_zero             = (fin_res == '0);
    end

    // Next-state logic for the stage registers and the output registers.
    // NOTE: every *_d gets its hold value first. A path that leaves a
    // variable unassigned in always_comb infers a latch.
    always_comb begin
        vld_d  = vld_q;
        cy_d   = cy_q;
        res_d  = res_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        for (int k = 0; k < NGRP; k++) begin
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
            sum_d[k] = sum_q[k];
        end
        if (advance) begin
            for (int k = 0; k < NGRP; k++) begin
                vld_d[k]              = src_v[k];
                opa_d[k]              = src_a[k];
                opb_d[k]              = src_b[k];
                sum_d[k]              = src_s[k];
                sum_d[k][4*k +: 4]    = grp[k][3:0];
                cy_d[k]               = grp[k][4];
            end
            // A bubble retiring leaves the output data untouched.
            if (src_v[NGRP-1]) begin
                res_d  = fin_res;
                cout_d = fin_cout;
                ovf_d  = fin_ovf;
                zero_d = fin_zero;
            end
        end
    end

    // Control and output registers, with synchronous reset.
    // NOTE: sequential state is updated with <= only. Blocking assignments
    // here would create ordering races between flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            res_q  <= res_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    // Datapath stage registers.
    // NOTE: these are deliberately not reset. They are qualified by vld_q,
    // so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        cy_q <= cy_d;
        for (int k = 0; k < NGRP; k++) begin
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
            sum_q[k] <= sum_d[k];
        end
    end

    assign out_valid = vld_q[NGRP-1];
    assign res       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_addsub_pipe
//   Scoreboard bench for cla_addsub_pipe (WIDTH=16).
//   - The driver pushes the model's expected response when a beat is accepted.
//   - The monitor pops and compares it when a result is handed off.
//   - The reference model uses plain integer arithmetic.
//   Honours CLA_ADDSUB_SAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_cla_addsub_pipe;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    exp_t         sb[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    int           n_pop  = 0;
    logic         rnd_en = 1'b0;
    logic         stalled = 1'b0;
    logic [W-1:0] held_res;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: integer arithmetic straight from the add/sub rules.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
        exp_t e;
        int ux, uy, sx, sy, u, t;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        u  = s ? (ux - uy) : (ux + uy);
        t  = s ? (sx - sy) : (sx + sy);
        e.res  = u[W-1:0];
        e.cout = s ? (ux >= uy) : (u > 65535);
        e.ovf  = (t > 32767) || (t < -32768);
`ifdef CLA_ADDSUB_SAT_EN
        if (e.ovf) e.res = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Offer one beat and hold it until accepted. The expected response is
    // queued at the handshake.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts);
        int guard;
        guard    = 0;
        a        = ta;
        b        = tb_;
        sub      = ts;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            guard++;
            if (guard > 200) begin
                n_vec++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
                break;
            end
        end
        if (guard <= 200) sb.push_back(model(ta, tb_, ts));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Random back-pressure, enabled only in the random phase.
    always @(posedge clk) begin
        #1;
        if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare each handed-off result with the head of the scoreboard.
    // Also checks in_ready and output stability while the output is stalled.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_hold", out_valid, 1);
                check("stall_res_hold", res, held_res);
            end
            if (out_valid === 1'b1) begin
                check("in_ready_vs_out_ready", in_ready, out_ready);
                if (out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_result: got res=0x%0h, expected no beat", res);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        n_pop++;
                        check("result", {13'd0, res, cout, ovf, zero},
                              {13'd0, e.res, e.cout, e.ovf, e.zero});
                    end
                end
                stalled  = (out_ready !== 1'b1);
                held_res = res;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        int pops_before;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {8'd0, out_valid, in_ready, res, cout, ovf, zero},
              {8'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;

        // Directed corner cases.
        send(16'h0008, 16'h0005, 1'b1);
        send(16'h0005, 16'h000B, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h0001, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        send(16'h0000, 16'h0000, 1'b0);
        drain();

        // Eight back-to-back beats with a three-cycle output stall.
        pops_before = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(W'($urandom), W'($urandom), 1'($urandom));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_pop - pops_before, 8);

        // Reset with three beats in flight: no result may appear afterwards.
        for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0101, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        send(16'h1234, 16'h0FFF, 1'b1);
        drain();

        // Random phase with random gaps and back-pressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h7FFF + W'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) rb = ra;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(ra, rb, 1'($urandom));
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
